// File: rtl/bird_pkg.sv
// ---------------------------------------------------------------------------
// bird_pkg
// Shared definitions for the bird sprite renderer and the position tracker:
//   START_X0 / START_Y0 : bird start coordinates (also the reset frame latch)
//   COL_*               : 24-bit {R,G,B} colours of each sprite part
//   pixel_class_t       : per-pixel part classification handed down the
//                         render pipeline
//   inRange             : inclusive range test on 11-bit sprite offsets
// ---------------------------------------------------------------------------
package bird_pkg;

    localparam logic [9:0] START_X0 = 10'd160;
    localparam logic [8:0] START_Y0 = 9'd240;

    localparam logic [23:0] COL_BODY = 24'hFFD700;
    localparam logic [23:0] COL_EYE  = 24'h000000;
    localparam logic [23:0] COL_BEAK = 24'hFF8000;
    localparam logic [23:0] COL_WING = 24'hFFFFFF;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_BODY,
        CLS_WING,
        CLS_BEAK,
        CLS_EYE
    } pixel_class_t;

    function automatic logic inRange(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bird_anim.sv
// ---------------------------------------------------------------------------
// bird_anim
// Wing-flap animation: counts frame_start pulses modulo WING_PERIOD and
// toggles the wing phase on the pulse that wraps the count back to zero.
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous, active-high
//   frame_start in  one-cycle pulse per frame
//   wing_up     out current wing phase (1 after reset)
// ---------------------------------------------------------------------------
module bird_anim
    import bird_pkg::*;
#(
    parameter int WING_PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    output logic wing_up
);

    // A period of 1 still needs a one-bit counter so the compare is legal.
    localparam int CW = (WING_PERIOD > 1) ? $clog2(WING_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(WING_PERIOD - 1);

    logic [CW-1:0] r_count;
    logic          r_wingUp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wingUp <= 1'b1;
        end else if (frame_start) begin
            if (r_count == LAST) begin
                r_count  <= '0;
                r_wingUp <= ~r_wingUp;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign wing_up = r_wingUp;

endmodule

// File: rtl/bird_sprite.sv
// ---------------------------------------------------------------------------
// bird_sprite
// Pixel-stream renderer for the bird sprite. The bird position is latched on
// frame_start so the sprite cannot tear mid-scan; each scan pixel then passes
// through a two-stage pipeline (region/offset, then class -> colour).
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   frame_start       one-cycle pulse at start of vertical blank
//   x0, y0            bird top-left from the position tracker
//   x, y, pixel_valid current scan pixel from the VGA driver
//   bird_on, r, g, b  per-pixel sprite flag and colour, 2 cycles after x/y
//   wing_up           current wing animation phase
// ---------------------------------------------------------------------------
module bird_sprite
    import bird_pkg::*;
#(
    parameter int BIRD_SIZE   = 15,
    parameter int WING_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [9:0] x0,
    input  logic [8:0] y0,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       pixel_valid,
    output logic       bird_on,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       wing_up
);

    localparam logic [10:0] SIZE11 = 11'(BIRD_SIZE);

    logic [9:0]   r_lx;
    logic [8:0]   r_ly;

    logic [10:0]  w_x11;
    logic [10:0]  w_y11;
    logic [10:0]  w_lx11;
    logic [10:0]  w_ly11;
    logic [10:0]  w_dx;
    logic [10:0]  w_dy;
    logic         w_inside;

    logic         r_s1Valid;
    logic         r_s1Inside;
    logic [10:0]  r_s1Dx;
    logic [10:0]  r_s1Dy;
    logic         r_s1WingUp;

    pixel_class_t w_class;

    logic         r_s2On;
    logic [23:0]  r_s2Col;

    logic         w_wingUp;

    bird_anim #(
        .WING_PERIOD (WING_PERIOD)
    ) u_anim (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .wing_up     (w_wingUp)
    );

    // Position latch: only frame_start moves the bird, so mid-frame tracker
    // updates never reach the scan-out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lx <= START_X0;
            r_ly <= START_Y0;
        end else if (frame_start) begin
            r_lx <= x0;
            r_ly <= y0;
        end
    end

    // Everything is widened to 11 bits so lx+BIRD_SIZE cannot overflow and a
    // bird near the bottom/right edge is simply clipped instead of wrapping.
    assign w_x11    = {1'b0, x};
    assign w_y11    = {2'b00, y};
    assign w_lx11   = {1'b0, r_lx};
    assign w_ly11   = {2'b00, r_ly};
    assign w_dx     = w_x11 - w_lx11;
    assign w_dy     = w_y11 - w_ly11;
    assign w_inside = (w_x11 >= w_lx11) && (w_x11 < w_lx11 + SIZE11) &&
                      (w_y11 >= w_ly11) && (w_y11 < w_ly11 + SIZE11);

    // Stage 1 also captures the wing phase, so a pixel sampled on the same
    // edge that toggles the wing still renders with the old phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1Valid  <= 1'b0;
            r_s1Inside <= 1'b0;
            r_s1Dx     <= '0;
            r_s1Dy     <= '0;
            r_s1WingUp <= 1'b1;
        end else begin
            r_s1Valid  <= pixel_valid;
            r_s1Inside <= w_inside;
            r_s1Dx     <= w_dx;
            r_s1Dy     <= w_dy;
            r_s1WingUp <= w_wingUp;
        end
    end

    // Part decode, highest priority first: eye, beak, wing, body.
    always_comb begin
        w_class = CLS_NONE;
        if (r_s1Valid && r_s1Inside) begin
            if (inRange(r_s1Dx, SIZE11 - 11'd5, SIZE11 - 11'd3) &&
                inRange(r_s1Dy, 11'd2, 11'd4)) begin
                w_class = CLS_EYE;
            end else if (inRange(r_s1Dx, SIZE11 - 11'd3, SIZE11 - 11'd1) &&
                         inRange(r_s1Dy, 11'd7, 11'd9)) begin
                w_class = CLS_BEAK;
            end else if (inRange(r_s1Dx, 11'd2, 11'd6) &&
                         (r_s1WingUp ? inRange(r_s1Dy, 11'd6, 11'd8)
                                     : inRange(r_s1Dy, 11'd9, 11'd11))) begin
                w_class = CLS_WING;
            end else begin
                w_class = CLS_BODY;
            end
        end
    end

    // Stage 2 turns the class into the final colour; non-bird pixels are black.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2On  <= 1'b0;
            r_s2Col <= '0;
        end else begin
            r_s2On <= (w_class != CLS_NONE);
            case (w_class)
                CLS_EYE:  r_s2Col <= COL_EYE;
                CLS_BEAK: r_s2Col <= COL_BEAK;
                CLS_WING: r_s2Col <= COL_WING;
                CLS_BODY: r_s2Col <= COL_BODY;
                default:  r_s2Col <= '0;
            endcase
        end
    end

    assign bird_on = r_s2On;
    assign r       = r_s2Col[23:16];
    assign g       = r_s2Col[15:8];
    assign b       = r_s2Col[7:0];
    assign wing_up = w_wingUp;

endmodule

// File: tb/tb_bird_sprite.sv
// ---------------------------------------------------------------------------
// tb_bird_sprite
// Directed bench for bird_sprite: reset, frame latch, pixel classes,
// boundaries, wing animation, gating and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_bird_sprite;

    localparam logic [24:0] OFF   = 25'h0_000000;
    localparam logic [24:0] BODY  = {1'b1, 24'hFFD700};
    localparam logic [24:0] EYE   = {1'b1, 24'h000000};
    localparam logic [24:0] BEAK  = {1'b1, 24'hFF8000};
    localparam logic [24:0] WING  = {1'b1, 24'hFFFFFF};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] x0 = '0;
    logic [8:0] y0 = '0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       pixel_valid = 1'b0;
    logic       bird_on;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       wing_up;

    int checks = 0;
    int failures = 0;

    logic [24:0] outVec;
    assign outVec = {bird_on, r, g, b};

    bird_sprite #(
        .BIRD_SIZE   (15),
        .WING_PERIOD (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .x0          (x0),
        .y0          (y0),
        .x           (x),
        .y           (y),
        .pixel_valid (pixel_valid),
        .bird_on     (bird_on),
        .r           (r),
        .g           (g),
        .b           (b),
        .wing_up     (wing_up)
    );

    always #5 clk = ~clk;

    // Drive one pixel and wait out the two-cycle latency; called at posedge+1.
    task automatic drivePixel(input logic [9:0] px, input logic [8:0] py,
                              input logic v);
        x = px;
        y = py;
        pixel_valid = v;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseFrame(input logic [9:0] nx, input logic [8:0] ny);
        x0 = nx;
        y0 = ny;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (outVec !== OFF) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", outVec, OFF);
        end
        checks++;
        if (wing_up !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_wing got=%b want=1", wing_up);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drivePixel(10'd160, 9'd240, 1'b1);
        checks++;
        if (outVec !== BODY) begin
            failures++;
            $display("[TB] FAIL reset_start_pos got=%h want=%h", outVec, BODY);
        end
    endtask

    task automatic test_frame_latch;
        // Pixel at the old position sampled together with the pulse.
        x = 10'd160;
        y = 9'd240;
        pixel_valid = 1'b1;
        pulseFrame(10'd100, 9'd50);
        x0 = 10'd300;
        @(posedge clk);
        #1;
        checks++;
        if (outVec !== BODY) begin
            failures++;
            $display("[TB] FAIL latch_same_cycle got=%h want=%h", outVec, BODY);
        end
        drivePixel(10'd105, 9'd50, 1'b1);
        checks++;
        if (bird_on !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latch_new_pos got=%b want=1", bird_on);
        end
        drivePixel(10'd300, 9'd50, 1'b1);
        checks++;
        if (bird_on !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latch_ignore_x0 got=%b want=0", bird_on);
        end
    endtask

    task automatic test_classes;
        logic [9:0]  tx [4] = '{10'd111, 10'd113, 10'd103, 10'd103};
        logic [8:0]  ty [4] = '{9'd53, 9'd58, 9'd57, 9'd60};
        logic [24:0] te [4] = '{EYE, BEAK, WING, BODY};
        for (int i = 0; i < 4; i++) begin
            drivePixel(tx[i], ty[i], 1'b1);
            checks++;
            if (outVec !== te[i]) begin
                failures++;
                $display("[TB] FAIL class_%0d (%0d,%0d) got=%h want=%h",
                         i, tx[i], ty[i], outVec, te[i]);
            end
        end
    endtask

    task automatic test_boundaries;
        logic [9:0]  tx [4] = '{10'd99, 10'd115, 10'd100, 10'd114};
        logic [8:0]  ty [4] = '{9'd50, 9'd50, 9'd65, 9'd64};
        logic [24:0] te [4] = '{OFF, OFF, OFF, BODY};
        for (int i = 0; i < 4; i++) begin
            drivePixel(tx[i], ty[i], 1'b1);
            checks++;
            if (outVec !== te[i]) begin
                failures++;
                $display("[TB] FAIL edge_%0d (%0d,%0d) got=%h want=%h",
                         i, tx[i], ty[i], outVec, te[i]);
            end
        end
        pulseFrame(10'd0, 9'd479);
        drivePixel(10'd0, 9'd479, 1'b1);
        checks++;
        if (outVec !== BODY) begin
            failures++;
            $display("[TB] FAIL edge_bottom got=%h want=%h", outVec, BODY);
        end
        drivePixel(10'd0, 9'd0, 1'b1);
        checks++;
        if (outVec !== OFF) begin
            failures++;
            $display("[TB] FAIL edge_nowrap got=%h want=%h", outVec, OFF);
        end
    endtask

    task automatic test_animation;
        // Start from a known counter value.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) pulseFrame(10'd100, 9'd50);
        checks++;
        if (wing_up !== 1'b1) begin
            failures++;
            $display("[TB] FAIL anim_after7 got=%b want=1", wing_up);
        end
        // Eighth pulse with a wing pixel sampled in the same cycle.
        x = 10'd103;
        y = 9'd57;
        pixel_valid = 1'b1;
        pulseFrame(10'd100, 9'd50);
        checks++;
        if (wing_up !== 1'b0) begin
            failures++;
            $display("[TB] FAIL anim_after8 got=%b want=0", wing_up);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outVec !== WING) begin
            failures++;
            $display("[TB] FAIL anim_old_phase got=%h want=%h", outVec, WING);
        end
        drivePixel(10'd103, 9'd57, 1'b1);
        checks++;
        if (outVec !== BODY) begin
            failures++;
            $display("[TB] FAIL anim_down_57 got=%h want=%h", outVec, BODY);
        end
        drivePixel(10'd103, 9'd60, 1'b1);
        checks++;
        if (outVec !== WING) begin
            failures++;
            $display("[TB] FAIL anim_down_60 got=%h want=%h", outVec, WING);
        end
    endtask

    task automatic test_gating_reset;
        drivePixel(10'd105, 9'd55, 1'b0);
        checks++;
        if (outVec !== OFF) begin
            failures++;
            $display("[TB] FAIL gate_invalid got=%h want=%h", outVec, OFF);
        end
        drivePixel(10'd105, 9'd55, 1'b1);
        checks++;
        if (outVec !== BODY) begin
            failures++;
            $display("[TB] FAIL gate_valid got=%h want=%h", outVec, BODY);
        end
        // Both stages now hold the inside pixel; reset must clear them at once.
        reset = 1'b1;
        #1;
        checks++;
        if (outVec !== OFF) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%h want=%h", outVec, OFF);
        end
        checks++;
        if (wing_up !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_wing got=%b want=1", wing_up);
        end
        pixel_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (outVec !== OFF) begin
                failures++;
                $display("[TB] FAIL postreset_%0d got=%h want=%h", i, outVec, OFF);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_latch();
        test_classes();
        test_boundaries();
        pulseFrame(10'd100, 9'd50);
        test_animation();
        test_gating_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
